// File: rtl/data_mem_pkg.sv
// Shared types for the data-memory responder: access sizes, FSM states and
// the byte-lane enable helper used by the store path.
package data_mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } mem_state_e;

  // Byte lanes touched by an aligned access of the given size at the given offset.
  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] en;
    case (size)
      BYTE:    en = 4'b0001 << offset;
      HALF:    en = 4'b0011 << offset;
      WORD:    en = 4'b1111;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/data_mem_load_align.sv
// Load-path lane select: picks the addressed byte/halfword out of a memory
// word and sign- or zero-extends it to 32 bits.
module load_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by extension; reserved sizes yield zero.
  always_comb begin
    byte_s = 8'd0;
    half_s = 16'd0;
    result = 32'd0;
    case (offset)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = 8'd0;
    endcase
    if (offset[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
    case (size)
      BYTE:    result = {{24{byte_s[7] & ~is_unsigned}}, byte_s};
      HALF:    result = {{16{half_s[15] & ~is_unsigned}}, half_s};
      WORD:    result = word;
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Data-memory responder: one request per handshake, little-endian byte/half/word
// accesses on a word-organised array, registered response one cycle after accept.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int MEM_SIZE = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_error_o
);

  localparam int ADDR_W = $clog2(MEM_SIZE);
  localparam int WORDS  = MEM_SIZE / 4;

  logic [31:0] mem_r [WORDS];

  mem_state_e  state_r;
  mem_state_e  state_next_s;
  logic [31:0] resp_rdata_r;
  logic        resp_error_r;

  logic              accept_s;
  logic              misaligned_s;
  logic              size_bad_s;
  logic              out_of_range_s;
  logic              error_s;
  logic              store_s;
  logic [ADDR_W-3:0] word_idx_s;
  logic [3:0]        byte_en_s;
  logic [31:0]       wlane_s;
  logic [31:0]       rword_s;
  logic [31:0]       load_data_s;

  assign resp_valid_o = (state_r == RESP);
  assign resp_rdata_o = resp_rdata_r;
  assign resp_error_o = resp_error_r;
  assign req_ready_o  = !reset && (!resp_valid_o || resp_ready_i);
  assign accept_s     = req_valid_i && req_ready_o;

  // Upper address bits must all be zero for the access to land in the array.
  assign out_of_range_s = |req_addr_i[31:ADDR_W];
  assign error_s        = misaligned_s || size_bad_s || out_of_range_s;
  assign store_s        = req_write_i && !error_s;
  assign word_idx_s     = req_addr_i[ADDR_W-1:2];
  assign byte_en_s      = lane_enable(req_size_i, req_addr_i[1:0]);
  assign rword_s        = mem_r[word_idx_s];

  // Alignment and size legality of the presented request.
  always_comb begin
    misaligned_s = 1'b0;
    size_bad_s   = 1'b0;
    case (req_size_i)
      BYTE:    misaligned_s = 1'b0;
      HALF:    misaligned_s = req_addr_i[0];
      WORD:    misaligned_s = |req_addr_i[1:0];
      default: size_bad_s   = 1'b1;
    endcase
  end

  // Replicate right-aligned store data onto every lane; byte enables pick the live ones.
  always_comb begin
    wlane_s = req_wdata_i;
    case (req_size_i)
      BYTE:    wlane_s = {4{req_wdata_i[7:0]}};
      HALF:    wlane_s = {2{req_wdata_i[15:0]}};
      WORD:    wlane_s = req_wdata_i;
      default: wlane_s = req_wdata_i;
    endcase
  end

  load_align u_load_align (
    .word        (rword_s),
    .offset      (req_addr_i[1:0]),
    .size        (req_size_i),
    .is_unsigned (req_unsigned_i),
    .result      (load_data_s)
  );

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (accept_s && store_s) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en_s[i]) begin
          mem_r[word_idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: a new accept always (re)loads the response; ready alone drains it.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = RESP;
        end else begin
          state_next_s = IDLE;
        end
      end
      RESP: begin
        if (accept_s) begin
          state_next_s = RESP;
        end else if (resp_ready_i) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Response payload registers, updated only on accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_rdata_r <= 32'd0;
      resp_error_r <= 1'b0;
    end else if (accept_s) begin
      resp_error_r <= error_s;
      if (error_s || req_write_i) begin
        resp_rdata_r <= 32'd0;
      end else begin
        resp_rdata_r <= load_data_s;
      end
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Directed plus randomized bench for data_mem, checked against a byte-array
// reference model built from the load/store rules.
module tb_data_mem;
  import data_mem_pkg::*;

  localparam int MEM_SIZE = 1024;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  int total = 0;
  int bad   = 0;

  byte unsigned ref_mem [MEM_SIZE];
  logic [31:0]  exp_rdata;
  logic         exp_err;

  always #5 clock = ~clock;

  data_mem #(.MEM_SIZE(MEM_SIZE)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_write_i    (req_write),
    .req_addr_i     (req_addr),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_wdata_i    (req_wdata),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_rdata_o   (resp_rdata),
    .resp_error_o   (resp_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: bytes in a flat array, loads assembled and extended arithmetically.
  function automatic void model(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                                input logic uns, input logic [31:0] wd);
    int n;
    longint v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp_rdata = 32'd0;
    exp_err = (sz == 2'd3) || ((a % n) != 0) || (longint'(a) >= MEM_SIZE);
    if (!exp_err) begin
      if (wr) begin
        for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = 8'(wd >> (8 * i));
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[int'(a) + i]) << (8 * i);
        if (!uns && v >= (64'sd1 << (8 * n - 1))) v -= (64'sd1 << (8 * n));
        exp_rdata = v[31:0];
      end
    end
  endfunction

  task automatic drive(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_write    = wr;
    req_addr     = a;
    req_size     = sz;
    req_unsigned = uns;
    req_wdata    = wd;
  endtask

  // Called at a negedge; leaves the bench at the next negedge with the response checked,
  // so consecutive calls issue one request per cycle.
  task automatic issue(input string tag, input logic wr, input logic [31:0] a, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd);
    drive(wr, a, sz, uns, wd);
    resp_ready = 1'b1;
    #1;
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    model(wr, a, sz, uns, wd);
    @(negedge clock);
    check({tag, " valid"}, 32'(resp_valid), 32'd1);
    check({tag, " rdata"}, resp_rdata, exp_rdata);
    check({tag, " error"}, 32'(resp_error), 32'(exp_err));
  endtask

  initial begin
    logic [31:0] held;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
    req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'd0; resp_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("rst valid", 32'(resp_valid), 32'd0);
    check("rst rdata", resp_rdata, 32'd0);
    check("rst error", 32'(resp_error), 32'd0);
    check("rst ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("post rst ready", 32'(req_ready), 32'd1);

    // Basic word round trip and extended sub-word loads.
    issue("st_w10", 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
    issue("ld_w10", 1'b0, 32'h10, 2'd2, 1'b0, 32'd0);
    check("ld_w10 const", resp_rdata, 32'hDEADBEEF);
    issue("ld_b13s", 1'b0, 32'h13, 2'd0, 1'b0, 32'd0);
    check("ld_b13s const", resp_rdata, 32'hFFFFFFDE);
    issue("ld_b13u", 1'b0, 32'h13, 2'd0, 1'b1, 32'd0);
    check("ld_b13u const", resp_rdata, 32'h000000DE);
    issue("ld_h10s", 1'b0, 32'h10, 2'd1, 1'b0, 32'd0);
    check("ld_h10s const", resp_rdata, 32'hFFFFBEEF);
    issue("ld_h12u", 1'b0, 32'h12, 2'd1, 1'b1, 32'd0);
    check("ld_h12u const", resp_rdata, 32'h0000DEAD);

    // Single-lane store with read-after-write on the very next cycle.
    issue("st_b11", 1'b1, 32'h11, 2'd0, 1'b0, 32'hAAAAAA55);
    issue("raw_w10", 1'b0, 32'h10, 2'd2, 1'b0, 32'd0);
    check("raw_w10 const", resp_rdata, 32'hDEAD55EF);

    // Error cases must not disturb the array.
    issue("st_w00", 1'b1, 32'h00, 2'd2, 1'b0, 32'h12345678);
    issue("err_h01", 1'b0, 32'h01, 2'd1, 1'b0, 32'd0);
    check("err_h01 const", 32'(resp_error), 32'd1);
    issue("err_w02", 1'b1, 32'h02, 2'd2, 1'b0, 32'hFFFFFFFF);
    check("err_w02 const", 32'(resp_error), 32'd1);
    issue("ld_w00", 1'b0, 32'h00, 2'd2, 1'b0, 32'd0);
    check("ld_w00 const", resp_rdata, 32'h12345678);
    issue("err_oor", 1'b0, 32'(MEM_SIZE), 2'd2, 1'b0, 32'd0);
    check("err_oor const", 32'(resp_error), 32'd1);
    issue("err_sz3ld", 1'b0, 32'h10, 2'd3, 1'b0, 32'd0);
    issue("err_sz3st", 1'b1, 32'h10, 2'd3, 1'b0, 32'h0);
    issue("ld_w10b", 1'b0, 32'h10, 2'd2, 1'b0, 32'd0);
    check("ld_w10b const", resp_rdata, 32'hDEAD55EF);

    // Backpressure: held response, stalled request, then release.
    held = resp_rdata;
    resp_ready = 1'b0;
    drive(1'b0, 32'h00, 2'd2, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp ready", 32'(req_ready), 32'd0);
      check("bp valid", 32'(resp_valid), 32'd1);
      check("bp rdata", resp_rdata, held);
      @(negedge clock);
    end
    resp_ready = 1'b1;
    #1;
    check("bp release ready", 32'(req_ready), 32'd1);
    model(1'b0, 32'h00, 2'd2, 1'b0, 32'd0);
    @(negedge clock);
    check("bp next valid", 32'(resp_valid), 32'd1);
    check("bp next rdata", resp_rdata, exp_rdata);

    // Reset while a response is held; a store offered during reset is ignored.
    issue("st_w20", 1'b1, 32'h20, 2'd2, 1'b0, 32'hCAFEF00D);
    issue("ld_w20", 1'b0, 32'h20, 2'd2, 1'b0, 32'd0);
    resp_ready = 1'b0;
    drive(1'b1, 32'h20, 2'd2, 1'b0, 32'h11111111);
    reset = 1'b1;
    #1;
    check("mid rst ready", 32'(req_ready), 32'd0);
    @(negedge clock);
    check("mid rst valid", 32'(resp_valid), 32'd0);
    check("mid rst rdata", resp_rdata, 32'd0);
    check("mid rst error", 32'(resp_error), 32'd0);
    check("mid rst ready2", 32'(req_ready), 32'd0);
    reset = 1'b0;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clock);
    check("after rst valid", 32'(resp_valid), 32'd0);
    issue("ld_w20r", 1'b0, 32'h20, 2'd2, 1'b0, 32'd0);
    check("ld_w20r const", resp_rdata, 32'hCAFEF00D);

    // Fill the low 256 bytes, then 8 back-to-back loads and a random mix.
    for (int i = 0; i < 64; i++) issue("fill", 1'b1, 32'(4 * i), 2'd2, 1'b0, $urandom);
    for (int i = 0; i < 8; i++) issue("stream", 1'b0, 32'(8 * i), 2'd2, 1'b0, 32'd0);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 15) == 0) a = 32'(MEM_SIZE) + $urandom_range(0, 4000);
      else a = $urandom_range(0, 255);
      issue("rnd", 1'(($urandom)), a, 2'($urandom), 1'($urandom), $urandom);
    end
    req_valid = 1'b0;
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
